// File: rtl/des_block_packer_if.sv
`default_nettype none
// ============================================================================
//  Module   : des_block_packer_if
//  Purpose  : Bundles the byte-stream, key, DES-core and ciphertext-output
//             signals of des_block_packer.
//  Modports :
//    master : upstream/downstream environment side. Drives key, bytes,
//             core result and Out_Ready.
//    slave  : packer side. Drives key/byte status, the core operands and
//             the ciphertext output.
//  Revision : 1.0 - initial release
// ============================================================================
interface des_block_packer_if;
  logic        Key_Load;
  logic [63:0] Key_In;
  logic        Key_Valid;
  logic [7:0]  Byte_In;
  logic        Byte_Valid;
  logic        Byte_Last;
  logic        Byte_Ready;
  logic [63:0] Blk_Data;
  logic [63:0] Blk_Key;
  logic [63:0] Enc_Data;
  logic [63:0] Out_Data;
  logic        Out_Valid;
  logic        Out_Ready;

  modport master (
    output Key_Load, Key_In, Byte_In, Byte_Valid, Byte_Last, Enc_Data, Out_Ready,
    input  Key_Valid, Byte_Ready, Blk_Data, Blk_Key, Out_Data, Out_Valid
  );

  modport slave (
    input  Key_Load, Key_In, Byte_In, Byte_Valid, Byte_Last, Enc_Data, Out_Ready,
    output Key_Valid, Byte_Ready, Blk_Data, Blk_Key, Out_Data, Out_Valid
  );
endinterface
`default_nettype wire

// File: rtl/des_block_packer.sv
`default_nettype none
// ============================================================================
//  Module   : des_block_packer
//  Purpose  : Packs plaintext bytes into 64-bit DES blocks (big-endian),
//             applies PKCS#5 padding at end of message, holds block and key
//             on a combinational DES core for SETTLE_CYCLES, then registers
//             the core result and offers it over a valid/ready handshake.
//  Ports    :
//    Clk     : rising-edge clock
//    Reset_n : asynchronous active-low reset
//    bus     : des_block_packer_if.slave (key load, byte stream, core
//              Data/Key/Encrypt_Data, ciphertext output handshake)
//  Params   :
//    SETTLE_CYCLES : 1..15, cycles the core operands are held before the
//                    result is sampled
//    PAD_EN        : 1 = PKCS#5 padding, 0 = zero-fill with no extra block
//  Revision : 1.0 - initial release
// ============================================================================
module des_block_packer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PAD_EN        = 1
) (
  input  wire logic         Clk,
  input  wire logic         Reset_n,
  des_block_packer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_PAD    = 2'd1,
    ST_SETTLE = 2'd2,
    ST_OUT    = 2'd3
  } state_t;

  localparam logic [3:0]  SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
  localparam logic [63:0] PAD_BLOCK   = {8{8'h08}};

  state_t      state;
  logic [2:0]  cnt;
  logic        pad_pending;
  logic        in_msg;       // bytes accepted since the last Byte_Last
  logic [3:0]  settle_cnt;
  logic [63:0] blk_data;
  logic [63:0] blk_key;
  logic        key_valid;
  logic [63:0] out_data;
  logic        out_valid;
  logic        byte_ready;

  logic        byte_accept;
  logic        key_load_ok;
  logic [7:0]  pad_val;

  // byte_ready is a register that always equals (state == FILL) && key_valid
  assign byte_accept = bus.Byte_Valid && byte_ready;
  assign key_load_ok = bus.Key_Load && (state == ST_FILL) && (cnt == 3'd0) && !in_msg;

  // In PAD, cnt already holds n (bytes including the last one): P = 8 - n
  assign pad_val = (PAD_EN != 0) ? {4'h0, 4'd8 - {1'b0, cnt}} : 8'h00;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_FILL;
      cnt         <= 3'd0;
      pad_pending <= 1'b0;
      in_msg      <= 1'b0;
      settle_cnt  <= 4'd0;
      blk_data    <= 64'd0;
      blk_key     <= 64'd0;
      key_valid   <= 1'b0;
      out_data    <= 64'd0;
      out_valid   <= 1'b0;
      byte_ready  <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          // A key load and a byte in the same cycle both take effect, so
          // the new key applies to the block being started.
          if (key_load_ok) begin
            blk_key    <= bus.Key_In;
            key_valid  <= 1'b1;
            byte_ready <= 1'b1;
          end
          if (byte_accept) begin
            for (int i = 0; i < 8; i++) begin
              if (cnt == 3'(i)) blk_data[8*(7-i) +: 8] <= bus.Byte_In;
            end
            cnt    <= cnt + 3'd1;
            in_msg <= !bus.Byte_Last;
            if (cnt == 3'd7) begin
              // A final byte that fills the block still owes a full pad block
              state       <= ST_SETTLE;
              settle_cnt  <= SETTLE_INIT;
              pad_pending <= bus.Byte_Last && (PAD_EN != 0);
              byte_ready  <= 1'b0;
            end else if (bus.Byte_Last) begin
              state      <= ST_PAD;
              byte_ready <= 1'b0;
            end
          end
        end

        ST_PAD: begin
          for (int i = 0; i < 8; i++) begin
            if (4'(i) >= {1'b0, cnt}) blk_data[8*(7-i) +: 8] <= pad_val;
          end
          state      <= ST_SETTLE;
          settle_cnt <= SETTLE_INIT;
        end

        ST_SETTLE: begin
          if (settle_cnt == 4'd0) begin
            out_data  <= bus.Enc_Data;
            out_valid <= 1'b1;
            state     <= ST_OUT;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end

        ST_OUT: begin
          if (bus.Out_Ready) begin
            out_valid <= 1'b0;
            cnt       <= 3'd0;
            if (pad_pending) begin
              pad_pending <= 1'b0;
              blk_data    <= PAD_BLOCK;
              state       <= ST_SETTLE;
              settle_cnt  <= SETTLE_INIT;
            end else begin
              state      <= ST_FILL;
              byte_ready <= key_valid;
            end
          end
        end

        default: begin
          state <= ST_FILL;
        end
      endcase
    end
  end

  assign bus.Key_Valid  = key_valid;
  assign bus.Byte_Ready = byte_ready;
  assign bus.Blk_Data   = blk_data;
  assign bus.Blk_Key    = blk_key;
  assign bus.Out_Data   = out_data;
  assign bus.Out_Valid  = out_valid;

endmodule
`default_nettype wire

// File: tb/tb_des_block_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_des_block_packer
//  Purpose  : Self-checking bench for des_block_packer. A stand-in for the
//             combinational DES core drives Enc_Data; expected blocks are
//             queued as bytes are driven and compared on each output
//             handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_des_block_packer;
  localparam int S = 2;
  localparam int P = 1;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  des_block_packer_if bus();

  des_block_packer #(.SETTLE_CYCLES(S), .PAD_EN(P)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  // Stand-in for the DES core: the real known-answer pair, otherwise a
  // cheap key-dependent scramble.
  function automatic logic [63:0] core_model(input logic [63:0] d, input logic [63:0] k);
    if (d == 64'h0123456789ABCDEF && k == 64'h133457799BBCDFF1)
      return 64'h85E813540F0AB405;
    return {d[31:0], d[63:32]} ^ k ^ 64'h5A5AC3C396960F0F;
  endfunction

  assign bus.Enc_Data = core_model(bus.Blk_Data, bus.Blk_Key);

  typedef struct packed {
    logic [63:0] pt;
    logic [63:0] ct;
  } exp_t;

  exp_t        sb[$];
  int          pop_cyc[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [63:0] key = 64'd0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Scoreboard: compare every completed handshake against the queue head
  always @(negedge Clk) begin
    if (Reset_n && bus.Out_Valid && bus.Out_Ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_output out_data=%h required=none", bus.Out_Data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        pop_cyc.push_back(cyc);
        if (bus.Out_Data !== e.ct) begin
          errors++;
          $display("FAIL sb_out_data got=%h required=%h", bus.Out_Data, e.ct);
        end
        checks++;
        if (bus.Blk_Data !== e.pt) begin
          errors++;
          $display("FAIL sb_blk_data got=%h required=%h", bus.Blk_Data, e.pt);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_n        = 1'b0;
    bus.Key_Load   = 1'b0;
    bus.Key_In     = 64'd0;
    bus.Byte_In    = 8'd0;
    bus.Byte_Valid = 1'b0;
    bus.Byte_Last  = 1'b0;
    bus.Out_Ready  = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    sb.delete();
  endtask

  task automatic load_key(input logic [63:0] k);
    bus.Key_Load = 1'b1;
    bus.Key_In   = k;
    tick();
    bus.Key_Load = 1'b0;
    key = k;
  endtask

  // Offers one byte and returns just after the edge that accepted it
  task automatic send_byte(input logic [7:0] b, input bit last);
    int n;
    n = 0;
    bus.Byte_In    = b;
    bus.Byte_Last  = last;
    bus.Byte_Valid = 1'b1;
    while (!bus.Byte_Ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL byte_ready_timeout got=0 required=1");
    end
    tick();
    bus.Byte_Valid = 1'b0;
    bus.Byte_Last  = 1'b0;
  endtask

  task automatic send_block(input logic [63:0] pt, input bit last_on_8);
    for (int i = 0; i < 8; i++) send_byte(pt[8*(7-i) +: 8], last_on_8 && (i == 7));
  endtask

  task automatic push_block(input logic [63:0] pt);
    exp_t e;
    e.pt = pt;
    e.ct = core_model(pt, key);
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d required=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (bus.Key_Valid !== 1'b0)   begin errors++; $display("FAIL reset_key_valid got=%b required=0", bus.Key_Valid); end
    if (bus.Byte_Ready !== 1'b0)  begin errors++; $display("FAIL reset_byte_ready got=%b required=0", bus.Byte_Ready); end
    if (bus.Out_Valid !== 1'b0)   begin errors++; $display("FAIL reset_out_valid got=%b required=0", bus.Out_Valid); end
    if (bus.Out_Data !== 64'd0)   begin errors++; $display("FAIL reset_out_data got=%h required=0", bus.Out_Data); end
    if (bus.Blk_Data !== 64'd0)   begin errors++; $display("FAIL reset_blk_data got=%h required=0", bus.Blk_Data); end
    if (bus.Blk_Key !== 64'd0)    begin errors++; $display("FAIL reset_blk_key got=%h required=0", bus.Blk_Key); end
  endtask

  task automatic test_no_key();
    bus.Byte_Valid = 1'b1;
    bus.Byte_In    = 8'h42;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks += 2;
      if (bus.Byte_Ready !== 1'b0) begin errors++; $display("FAIL nokey_byte_ready got=%b required=0", bus.Byte_Ready); end
      if (bus.Out_Valid !== 1'b0)  begin errors++; $display("FAIL nokey_out_valid got=%b required=0", bus.Out_Valid); end
    end
    bus.Byte_Valid = 1'b0;
  endtask

  task automatic test_kat();
    load_key(64'h133457799BBCDFF1);
    checks++;
    if (bus.Key_Valid !== 1'b1) begin errors++; $display("FAIL kat_key_valid got=%b required=1", bus.Key_Valid); end
    bus.Out_Ready = 1'b0;
    push_block(64'h0123456789ABCDEF);
    send_block(64'h0123456789ABCDEF, 1'b0);
    checks += 3;
    if (bus.Blk_Data !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL kat_blk_data got=%h required=0123456789abcdef", bus.Blk_Data); end
    if (bus.Byte_Ready !== 1'b0) begin errors++; $display("FAIL kat_byte_ready got=%b required=0", bus.Byte_Ready); end
    if (bus.Out_Valid !== 1'b0)  begin errors++; $display("FAIL kat_early_valid got=%b required=0", bus.Out_Valid); end
    for (int k = 1; k < S; k++) begin
      tick();
      checks++;
      if (bus.Out_Valid !== 1'b0) begin errors++; $display("FAIL kat_early_valid cycle=%0d got=%b required=0", k, bus.Out_Valid); end
    end
    tick();
    checks += 2;
    if (bus.Out_Valid !== 1'b1) begin errors++; $display("FAIL kat_valid_latency got=%b required=1", bus.Out_Valid); end
    if (bus.Out_Data !== 64'h85E813540F0AB405) begin errors++; $display("FAIL kat_out_data got=%h required=85e813540f0ab405", bus.Out_Data); end
    bus.Out_Ready = 1'b1;
    drain("kat");
  endtask

  task automatic test_pad();
    bus.Out_Ready = 1'b1;
    push_block(64'hAABBCC0505050505);
    send_byte(8'hAA, 1'b0);
    // Mid-message key load must be ignored
    bus.Key_Load = 1'b1;
    bus.Key_In   = 64'hFFEEDDCCBBAA9988;
    send_byte(8'hBB, 1'b0);
    bus.Key_Load = 1'b0;
    send_byte(8'hCC, 1'b1);
    checks += 2;
    if (bus.Out_Valid !== 1'b0) begin errors++; $display("FAIL pad_early_valid got=%b required=0", bus.Out_Valid); end
    if (bus.Blk_Key !== key)    begin errors++; $display("FAIL pad_key_ignored got=%h required=%h", bus.Blk_Key, key); end
    for (int k = 1; k <= S; k++) begin
      tick();
      checks++;
      if (bus.Out_Valid !== 1'b0) begin errors++; $display("FAIL pad_early_valid cycle=%0d got=%b required=0", k, bus.Out_Valid); end
      if (k == 1) begin
        checks++;
        if (bus.Blk_Data !== 64'hAABBCC0505050505) begin errors++; $display("FAIL pad_blk_data got=%h required=aabbcc0505050505", bus.Blk_Data); end
      end
    end
    tick();
    checks++;
    if (bus.Out_Valid !== 1'b1) begin errors++; $display("FAIL pad_valid_latency got=%b required=1", bus.Out_Valid); end
    tick();
    checks += 2;
    if (bus.Out_Valid !== 1'b0)  begin errors++; $display("FAIL pad_single_output got=%b required=0", bus.Out_Valid); end
    if (bus.Byte_Ready !== 1'b1) begin errors++; $display("FAIL pad_back_to_fill got=%b required=1", bus.Byte_Ready); end
    drain("pad");
  endtask

  task automatic test_full_final();
    logic [63:0] pt;
    int n;
    pt = 64'h1020304050607080;
    bus.Out_Ready = 1'b1;
    key = 64'h0E329232EA6D0D73;
    push_block(pt);
    push_block(64'h0808080808080808);
    // Key load coinciding with the first byte applies to this block
    bus.Key_Load = 1'b1;
    bus.Key_In   = key;
    send_byte(pt[63:56], 1'b0);
    bus.Key_Load = 1'b0;
    for (int i = 1; i < 8; i++) send_byte(pt[8*(7-i) +: 8], i == 7);
    checks++;
    if (bus.Blk_Key !== key) begin errors++; $display("FAIL full_key_same_cycle got=%h required=%h", bus.Blk_Key, key); end
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      checks++;
      if (bus.Byte_Ready !== 1'b0) begin errors++; $display("FAIL full_byte_ready_early got=%b required=0", bus.Byte_Ready); end
      tick();
      n++;
    end
    checks += 2;
    if (sb.size() != 0)          begin errors++; $display("FAIL full_two_blocks pending=%0d required=0", sb.size()); sb.delete(); end
    if (bus.Byte_Ready !== 1'b1) begin errors++; $display("FAIL full_byte_ready_after got=%b required=1", bus.Byte_Ready); end
  endtask

  task automatic test_backpressure();
    logic [63:0] pt;
    logic [63:0] snap;
    int n;
    pt = {$urandom(), $urandom()};
    bus.Out_Ready = 1'b0;
    push_block(pt);
    send_block(pt, 1'b0);
    n = 0;
    while (!bus.Out_Valid && n < 50) begin
      tick();
      n++;
    end
    snap = bus.Out_Data;
    checks++;
    if (snap !== sb[0].ct) begin errors++; $display("FAIL bp_out_data got=%h required=%h", snap, sb[0].ct); end
    bus.Byte_Valid = 1'b1;
    bus.Byte_In    = 8'h5C;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks += 3;
      if (bus.Out_Valid !== 1'b1)  begin errors++; $display("FAIL bp_out_valid_hold got=%b required=1", bus.Out_Valid); end
      if (bus.Out_Data !== snap)   begin errors++; $display("FAIL bp_out_data_hold got=%h required=%h", bus.Out_Data, snap); end
      if (bus.Byte_Ready !== 1'b0) begin errors++; $display("FAIL bp_byte_ready got=%b required=0", bus.Byte_Ready); end
    end
    bus.Byte_Valid = 1'b0;
    bus.Out_Ready  = 1'b1;
    drain("bp");
    // Next block shows whether the byte offered under backpressure leaked in
    push_block(64'h1122330505050505);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    drain("bp_tail");
  endtask

  task automatic test_back_to_back();
    bus.Out_Ready = 1'b1;
    pop_cyc.delete();
    push_block(64'hA1A2A3A4A5A6A7A8);
    push_block(64'hB1B2B3B4B5B6B7B8);
    send_block(64'hA1A2A3A4A5A6A7A8, 1'b0);
    send_block(64'hB1B2B3B4B5B6B7B8, 1'b0);
    drain("b2b");
    checks++;
    if (pop_cyc.size() != 2) begin
      errors++;
      $display("FAIL b2b_outputs got=%0d required=2", pop_cyc.size());
    end else if (pop_cyc[1] - pop_cyc[0] != 8 + S + 1) begin
      errors++;
      $display("FAIL b2b_period got=%0d required=%0d", pop_cyc[1] - pop_cyc[0], 8 + S + 1);
    end
  endtask

  task automatic test_reset_mid();
    bus.Out_Ready = 1'b0;
    push_block(64'hC0C1C2C3C4C5C6C7);
    send_block(64'hC0C1C2C3C4C5C6C7, 1'b0);
    #2;
    Reset_n = 1'b0;
    #1;
    checks += 6;
    if (bus.Blk_Data !== 64'd0)  begin errors++; $display("FAIL rstmid_blk_data got=%h required=0", bus.Blk_Data); end
    if (bus.Blk_Key !== 64'd0)   begin errors++; $display("FAIL rstmid_blk_key got=%h required=0", bus.Blk_Key); end
    if (bus.Out_Data !== 64'd0)  begin errors++; $display("FAIL rstmid_out_data got=%h required=0", bus.Out_Data); end
    if (bus.Out_Valid !== 1'b0)  begin errors++; $display("FAIL rstmid_out_valid got=%b required=0", bus.Out_Valid); end
    if (bus.Key_Valid !== 1'b0)  begin errors++; $display("FAIL rstmid_key_valid got=%b required=0", bus.Key_Valid); end
    if (bus.Byte_Ready !== 1'b0) begin errors++; $display("FAIL rstmid_byte_ready got=%b required=0", bus.Byte_Ready); end
    sb.delete();
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    tick();
    checks++;
    if (bus.Key_Valid !== 1'b0) begin errors++; $display("FAIL rstmid_key_after got=%b required=0", bus.Key_Valid); end
    load_key(64'h133457799BBCDFF1);
    bus.Out_Ready = 1'b1;
    push_block(64'h0123456789ABCDEF);
    send_block(64'h0123456789ABCDEF, 1'b0);
    drain("rstmid");
  endtask

  initial begin
    test_reset();
    test_no_key();
    test_kat();
    test_pad();
    test_full_final();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/des_block_packer.md
# des_block_packer

Byte-stream front end for the combinational DES encryption core. Packs incoming plaintext bytes into 64-bit blocks, applies PKCS#5 padding at end of message, holds the block and key stable on the core's `Data`/`Key` inputs for a fixed settle window, then registers the core's 64-bit result and hands it downstream over a valid/ready handshake. The block sits directly upstream of the encrypt core and also captures that core's output.

## Interface

Parameters:
- `SETTLE_CYCLES`, default 2: cycles that `Blk_Data`/`Blk_Key` are held before `Enc_Data` is sampled (multicycle path through the core). Legal range 1–15.
- `PAD_EN`, default 1:
  - 1: PKCS#5 padding.
  - 0: a partial final block is zero-filled and no extra block is generated.

Ports:
- `Clk` in 1: rising-edge clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Key_Load` in 1: single-cycle strobe that captures `Key_In`.
- `Key_In` in 64: DES key, including parity bits.
- `Key_Valid` out 1: a key has been loaded since reset.
- `Byte_In` in 8: plaintext byte.
- `Byte_Valid` in 1: `Byte_In` is valid.
- `Byte_Last` in 1: qualifies the accepted byte as the final byte of the message.
- `Byte_Ready` out 1: the block can accept a byte this cycle.
- `Blk_Data` out 64: to the core's `Data` input.
- `Blk_Key` out 64: to the core's `Key` input.
- `Enc_Data` in 64: from the core's `Encrypt_Data` output.
- `Out_Data` out 64: registered ciphertext block.
- `Out_Valid` out 1: `Out_Data` is valid.
- `Out_Ready` in 1: downstream accepts `Out_Data`.

## Operation

States:
- `FILL`: accepting bytes.
- `PAD`: inserting pad bytes.
- `SETTLE`: holding the block on the core.
- `OUT`: presenting the result downstream.

Byte acceptance:
- A byte is accepted on `Byte_Valid && Byte_Ready`.
- `Byte_Ready = (state == FILL) && Key_Valid`.

Packing:
- Byte 0 of a block goes to `Blk_Data[63:56]`, byte 7 to `[7:0]` (DES big-endian order).
- A 3-bit `cnt` holds the number of bytes already in the block.

Key loading:
- `Key_Load` is honoured only in `FILL` with `cnt == 0` and no message in progress (no accepted bytes since the last `Byte_Last`). Otherwise it is ignored.
- On load, `Blk_Key <= Key_In` and `Key_Valid <= 1`.
- `Key_Valid` is cleared only by reset.

Transitions:
- `FILL`, 8th byte accepted (`cnt == 7`) → `SETTLE`. If that byte carries `Byte_Last` and `PAD_EN == 1`, set the `pad_pending` flag.
- `FILL`, `Byte_Last` accepted with `cnt < 7` → `PAD`.
- `PAD`: in one cycle, write every remaining byte position with pad value P, then → `SETTLE`.
  - P = 8 − n, where n is the byte count including the last byte.
  - P = 0x00 when `PAD_EN == 0`.
- `SETTLE`:
  - On entry, a down-counter loads `SETTLE_CYCLES − 1`.
  - On the edge where the counter is 0: `Out_Data <= Enc_Data`, `Out_Valid <= 1`, → `OUT`.
- `OUT`, `Out_Ready == 1`:
  - `Out_Valid <= 0`, `cnt <= 0`.
  - If `pad_pending`: clear it, set `Blk_Data <= 64'h0808080808080808`, → `SETTLE`.
  - Otherwise → `FILL`.

Other rules:
- `Blk_Data` and `Blk_Key` do not change in `SETTLE` or `OUT`.
- `Byte_Last` with `Byte_Valid` low, or with `Byte_Ready` low, has no effect.

## Timing

- Reset (asynchronous, active-low):
  - State → `FILL`.
  - `cnt = 0`, `pad_pending = 0`.
  - `Blk_Data = 0`, `Blk_Key = 0`, `Out_Data = 0`.
  - `Out_Valid = 0`, `Key_Valid = 0`, `Byte_Ready = 0`.
  - Reset mid-message discards the partial block, any pending output and the key.
- Full block: the 8th byte is accepted at edge E. `Out_Valid` is high from edge E + `SETTLE_CYCLES` onward.
- Partial final block: `Byte_Last` is accepted at edge E. `PAD` occupies one cycle, and `Out_Valid` is high from edge E + 1 + `SETTLE_CYCLES`.
- Throughput: with `Out_Ready` tied high, one block per 8 + `SETTLE_CYCLES` + 1 cycles.
- Backpressure:
  - `Out_Valid` and `Out_Data` hold until `Out_Ready`.
  - `Byte_Ready` stays low in `PAD`/`SETTLE`/`OUT`.
- Handshake completes in the same cycle: `Out_Ready` may be high in the first `OUT` cycle, in which case `Out_Valid` is high for exactly one cycle.
- `Byte_Ready` returns high the cycle after the output handshake, unless a pad block is pending.
- `Key_Load` together with `Byte_Valid` in the same cycle, with `cnt == 0` and `Key_Valid == 1`: the key loads and the byte is accepted. The new key applies to that block.

## Test plan

- **No key loaded:** reset, then drive `Byte_Valid` with no key → `Byte_Ready` stays 0, no output.
- **DES known-answer vector:**
  - Stimulus: load key `133457799BBCDFF1`, stream bytes 01 23 45 67 89 AB CD EF (no `Byte_Last`).
  - Response: `Blk_Data == 0123456789ABCDEF` during `SETTLE`, `Out_Data == 85E813540F0AB405` with `Out_Valid` rising exactly `SETTLE_CYCLES` edges after the 8th byte.
- **Partial block padding:** bytes AA BB CC with `Byte_Last` on CC → `Blk_Data == AABBCC0505050505`, one output block, then back to `FILL` with `Byte_Ready == 1`.
- **Full final block:** 8 bytes with `Byte_Last` on the 8th → two output blocks. The second is sampled with `Blk_Data == 0808080808080808`, and `Byte_Ready` stays 0 until the second handshake.
- **Backpressure:** `Out_Ready` held low 10 cycles → `Out_Valid` and `Out_Data` stable, `Byte_Ready == 0`, and bytes offered meanwhile are not consumed.
- **Reset mid-operation:** assert `Reset_n` low during `SETTLE` → all outputs 0 immediately (asynchronously). After reset, `Key_Valid == 0` and a new key plus 8 bytes encrypts correctly.
